// File: rtl/avr_io_ps2_pkg.sv
// Shared constants for the PS/2 receiver: register map, STATUS/CTRL bit positions,
// receive FSM encoding.
package avr_io_ps2_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_AVAIL = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_PERR  = 3;
    localparam int ST_FERR  = 4;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/avr_ps2_fifo.sv
// Synchronous scancode FIFO; push when full and pop when empty are ignored.
module avr_ps2_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [FIFO_DEPTH_LOG2:0] count,
    output logic                     full,
    output logic                     empty
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/avr_io_ps2.sv
// PS/2 keyboard receiver on the AVR I/O bus. Optional PS2_GLITCH_FILTER_EN adds an
// 8-cycle stability filter on the synchronised PS2Clk before edge detection.
module avr_io_ps2
    import avr_io_ps2_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int TIMEOUT         = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [1:0] io_a,
    input  logic [7:0] io_do,
    output logic [7:0] io_di,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       irq
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, clk_prev_q;
    logic       clk_src, fall;
    rx_state_e  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic       ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
    logic       en_q, en_d, ie_q, ie_d, irq_q, irq_d;
    logic       push, pop, ovr_set, perr_set, ferr_set, wr_status;
    logic [7:0] fifo_dout;
    logic [FIFO_DEPTH_LOG2:0] unused_count;
    logic       full, empty;

`ifdef PS2_GLITCH_FILTER_EN
    logic       clk_flt_q, clk_flt_d;
    logic [2:0] flt_cnt_q, flt_cnt_d;

    // Filtered level follows the input only after 8 consecutive cycles at the new level.
    always_comb begin
        clk_flt_d = clk_flt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != clk_flt_q) begin
            flt_cnt_d = flt_cnt_q + 3'd1;
            if (flt_cnt_q == 3'd7) begin
                clk_flt_d = clk_s2_q;
                flt_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_flt_q <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            clk_flt_q <= clk_flt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign clk_src = clk_flt_q;
`else
    assign clk_src = clk_s2_q;
`endif

    assign fall      = clk_prev_q & ~clk_src;
    assign pop       = io_re && (io_a == REG_DATA);
    assign wr_status = io_we && (io_a == REG_STATUS);

    avr_ps2_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (shreg_q),
        .dout  (fifo_dout),
        .count (unused_count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        ovr_set   = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (!en_q) begin
            state_d = S_IDLE;
            tmo_d   = '0;
        end else if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
            state_d  = S_IDLE;
            tmo_d    = '0;
            ferr_set = 1'b1;
        end else begin
            tmo_d = (fall || state_q == S_IDLE) ? '0 : tmo_q + TW'(1);
            if (fall) begin
                case (state_q)
                    S_IDLE: if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                    S_DATA: begin
                        shreg_d   = {dat_s2_q, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                    end
                    S_PARITY: begin
                        par_d   = dat_s2_q;
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        if (!dat_s2_q)                 ferr_set = 1'b1;
                        else if (!(^{shreg_q, par_q})) perr_set = 1'b1;
                        else if (full)                 ovr_set  = 1'b1;
                        else                           push     = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // A flag set in the same cycle as its write-1-clear wins.
        ovr_d  = (ovr_q  & ~(wr_status & io_do[ST_OVR]))  | ovr_set;
        perr_d = (perr_q & ~(wr_status & io_do[ST_PERR])) | perr_set;
        ferr_d = (ferr_q & ~(wr_status & io_do[ST_FERR])) | ferr_set;
        en_d   = en_q;
        ie_d   = ie_q;
        if (io_we && io_a == REG_CTRL) begin
            en_d = io_do[CTRL_EN];
            ie_d = io_do[CTRL_IE];
        end
        irq_d = ie_q & (~empty | ovr_q | perr_q | ferr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ovr_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            clk_prev_q <= clk_src;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ovr_q      <= ovr_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        io_di = 8'h00;
        case (io_a)
            REG_DATA:   io_di = empty ? 8'h00 : fifo_dout;
            REG_STATUS: begin
                io_di[ST_AVAIL] = ~empty;
                io_di[ST_FULL]  = full;
                io_di[ST_OVR]   = ovr_q;
                io_di[ST_PERR]  = perr_q;
                io_di[ST_FERR]  = ferr_q;
            end
            REG_CTRL: begin
                io_di[CTRL_EN] = en_q;
                io_di[CTRL_IE] = ie_q;
            end
            default: io_di = 8'h00;
        endcase
    end

endmodule
